// File: rtl/rx_frame_pkg.sv
// rtl/rx_frame_pkg.sv - shared state encodings, error codes and defaults for the frame receiver
package rx_frame_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LEN  = 2'd1,
        ST_PAY  = 2'd2,
        ST_CSUM = 2'd3
    } rx_state_t;

    localparam logic [1:0] ERR_TIMEOUT = 2'd0;
    localparam logic [1:0] ERR_LINE    = 2'd1;
    localparam logic [1:0] ERR_LEN     = 2'd2;
    localparam logic [1:0] ERR_CSUM    = 2'd3;

    localparam logic [7:0] SOF_DEFAULT = 8'h7E;

endpackage

// File: rtl/rx_frame_csum.sv
// rtl/rx_frame_csum.sv - 8-bit modular checksum accumulator with load, add and compare
module rx_frame_csum (
    input  logic       clk,
    input  logic       rst,
    input  logic       load_i,
    input  logic [7:0] load_val_i,
    input  logic       add_i,
    input  logic [7:0] add_val_i,
    input  logic [7:0] cmp_i,
    output logic [7:0] sum_o,
    output logic       match_o
);

    logic [7:0] sum_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q <= 8'h00;
        end else if (load_i) begin
            sum_q <= load_val_i;
        end else if (add_i) begin
            sum_q <= sum_q + add_val_i;
        end
    end

    assign sum_o   = sum_q;
    assign match_o = (cmp_i == sum_q);

endmodule

// File: rtl/rx_frame_ctrl.sv
// rtl/rx_frame_ctrl.sv - UART byte sequencer and SOF/LEN/payload/CSUM frame parser
// Optional inter-byte timeout enabled by defining RX_FRAME_TIMEOUT_EN.
module rx_frame_ctrl
    import rx_frame_pkg::*;
#(
    parameter logic [7:0] SOF_BYTE    = SOF_DEFAULT,
    parameter int         MAX_LEN     = 16,
    parameter int         TIMEOUT_CYC = 4096
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_po,
    input  logic       rx_ready,
    input  logic       rx_error,
    output logic       rx_data_ack,
    output logic [7:0] frm_data,
    output logic       frm_valid,
    output logic       frm_last,
    input  logic       frm_ready,
    output logic       frm_done,
    output logic       frm_err,
    output logic [1:0] err_code
);

    rx_state_t  state_q;
    logic       ack_wait_q;
    logic       rx_data_ack_q;
    logic [7:0] frm_data_q;
    logic       frm_valid_q;
    logic       frm_last_q;
    logic       frm_done_q;
    logic       frm_err_q;
    logic [1:0] err_code_q;
    logic [7:0] count_q;

    logic       byte_avail;
    logic       accept;
    logic       len_ok;
    logic       csum_load;
    logic       csum_add;
    logic       csum_match;
    logic [7:0] csum_sum;
    logic       timeout;

    assign byte_avail = rx_ready & ~ack_wait_q;
    assign len_ok     = (rx_po != 8'd0) && (rx_po <= 8'(MAX_LEN));

    // In PAY the byte is consumed only once the downstream takes the beat,
    // except a line-error byte, which is consumed without being forwarded.
    always_comb begin
        accept = byte_avail;
        if (state_q == ST_PAY) begin
            accept = byte_avail & (frm_valid_q ? frm_ready : rx_error);
        end
    end

    assign csum_load = (state_q == ST_LEN) & accept & ~rx_error;
    assign csum_add  = (state_q == ST_PAY) & accept & frm_valid_q;

    rx_frame_csum u_csum (
        .clk        (clk),
        .rst        (rst),
        .load_i     (csum_load),
        .load_val_i (rx_po),
        .add_i      (csum_add),
        .add_val_i  (frm_data_q),
        .cmp_i      (rx_po),
        .sum_o      (csum_sum),
        .match_o    (csum_match)
    );

`ifdef RX_FRAME_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT_CYC);

    logic [TMR_W-1:0] timer_q;
    logic             unused_csum;

    assign unused_csum = |csum_sum;
    assign timeout = (state_q != ST_IDLE) && !accept &&
                     (timer_q == TMR_W'(TIMEOUT_CYC - 1));

    // Time spent waiting on a stalled downstream is not charged to the sender.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer_q <= '0;
        end else if ((state_q == ST_IDLE) || accept || timeout) begin
            timer_q <= '0;
        end else if (!(frm_valid_q && !frm_ready)) begin
            timer_q <= timer_q + 1'b1;
        end
    end
`else
    logic unused_timeout;

    assign unused_timeout = (|TIMEOUT_CYC) ^ (|csum_sum);
    assign timeout        = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            ack_wait_q    <= 1'b0;
            rx_data_ack_q <= 1'b0;
            frm_data_q    <= 8'h00;
            frm_valid_q   <= 1'b0;
            frm_last_q    <= 1'b0;
            frm_done_q    <= 1'b0;
            frm_err_q     <= 1'b0;
            err_code_q    <= ERR_TIMEOUT;
            count_q       <= 8'h00;
        end else begin
            rx_data_ack_q <= accept;
            frm_done_q    <= 1'b0;
            frm_err_q     <= 1'b0;

            if (accept) begin
                ack_wait_q <= 1'b1;
            end else if (!rx_ready) begin
                ack_wait_q <= 1'b0;
            end

            if (timeout) begin
                state_q     <= ST_IDLE;
                frm_valid_q <= 1'b0;
                frm_last_q  <= 1'b0;
                frm_err_q   <= 1'b1;
                err_code_q  <= ERR_TIMEOUT;
            end else if (accept && rx_error && (state_q != ST_IDLE)) begin
                state_q     <= ST_IDLE;
                frm_valid_q <= 1'b0;
                frm_last_q  <= 1'b0;
                frm_err_q   <= 1'b1;
                err_code_q  <= ERR_LINE;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (accept && !rx_error && (rx_po == SOF_BYTE)) begin
                            state_q <= ST_LEN;
                        end
                    end
                    ST_LEN: begin
                        if (accept) begin
                            count_q <= rx_po;
                            if (len_ok) begin
                                state_q <= ST_PAY;
                            end else begin
                                state_q    <= ST_IDLE;
                                frm_err_q  <= 1'b1;
                                err_code_q <= ERR_LEN;
                            end
                        end
                    end
                    ST_PAY: begin
                        if (!frm_valid_q) begin
                            if (byte_avail) begin
                                frm_valid_q <= 1'b1;
                                frm_data_q  <= rx_po;
                                frm_last_q  <= (count_q == 8'd1);
                            end
                        end else if (accept) begin
                            frm_valid_q <= 1'b0;
                            frm_last_q  <= 1'b0;
                            count_q     <= count_q - 8'd1;
                            if (count_q == 8'd1) begin
                                state_q <= ST_CSUM;
                            end
                        end
                    end
                    ST_CSUM: begin
                        if (accept) begin
                            state_q <= ST_IDLE;
                            if (csum_match) begin
                                frm_done_q <= 1'b1;
                            end else begin
                                frm_err_q  <= 1'b1;
                                err_code_q <= ERR_CSUM;
                            end
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign rx_data_ack = rx_data_ack_q;
    assign frm_data    = frm_data_q;
    assign frm_valid   = frm_valid_q;
    assign frm_last    = frm_last_q;
    assign frm_done    = frm_done_q;
    assign frm_err     = frm_err_q;
    assign err_code    = err_code_q;

endmodule
